// File: rtl/aes_dec_pkg.sv
// Shared constants and types for the AES-256 decryption key path.
package aes_dec_pkg;

    localparam int NR    = 14;
    localparam int KEY_W = 256;
    localparam int RK_W  = 128;
    localparam int IDX_W = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);

    typedef logic [0:RK_W-1] rkey_t;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        CAPTURE,
        READY,
        STREAM
    } sched_state_e;

endpackage

// File: rtl/aes_rkey_regfile.sv
// Round-key store: NR+1 entries, one synchronous write port, one combinational read port.
module aes_rkey_regfile
    import aes_dec_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [RK_W-1:0]  wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [RK_W-1:0]  rdata
);

    rkey_t mem [0:NR];

    // NOTE: the key storage is deliberately not reset; key_valid alone says whether its contents mean anything.
    always_ff @(posedge clk) begin
        if (we && waddr <= LAST_IDX) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (raddr <= LAST_IDX) ? mem[raddr] : '0;

endmodule

// File: rtl/aes_rkey_sched_ctrl.sv
// Key-load / round-key capture / reverse-order streaming controller for AES-256 decryption.
module aes_rkey_sched_ctrl
    import aes_dec_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_vld,
    output logic             key_rdy,
    output logic [KEY_W-1:0] exp_kt,
    output logic             exp_kt_vld,
    input  logic             exp_kt_rdy,
    input  logic [RK_W-1:0]  exp_rkey,
    input  logic             exp_rkey_vld,
    input  logic             exp_rkey_last,
    output logic             key_valid,
    output logic             key_err,
    input  logic             strm_start,
    output logic             strm_rdy,
    output logic [RK_W-1:0]  rk_data,
    output logic [IDX_W-1:0] rk_idx,
    output logic             rk_vld,
    input  logic             rk_rdy,
    output logic             rk_last
);

    sched_state_e     state;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] rd_ptr;
    logic             key_accept;
    logic             rf_we;
    logic [IDX_W-1:0] rf_waddr;
    logic [IDX_W-1:0] rf_raddr;
    logic [RK_W-1:0]  rf_rdata;

    assign key_rdy    = (state == IDLE || state == READY) && !strm_start;
    assign strm_rdy   = (state == READY);
    assign key_accept = key_vld && key_rdy;

    // Round key 0 arrives in the launch handshake cycle itself, so slot 0 is written there.
    assign rf_we    = (state == LAUNCH && exp_kt_rdy) || (state == CAPTURE && exp_rkey_vld);
    assign rf_waddr = (state == LAUNCH) ? '0 : cnt;
    // Outside STREAM the read port looks at slot NR so the first beat can load on stream entry.
    assign rf_raddr = (state == STREAM) ? rd_ptr - IDX_W'(1) : LAST_IDX;

    aes_rkey_regfile u_regfile (
        .clk   (clk),
        .we    (rf_we),
        .waddr (rf_waddr),
        .wdata (exp_rkey),
        .raddr (rf_raddr),
        .rdata (rf_rdata)
    );

    // NOTE: all state lives in this one clocked block with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            key_valid  <= 1'b0;
            key_err    <= 1'b0;
            rk_vld     <= 1'b0;
            rk_last    <= 1'b0;
            exp_kt_vld <= 1'b0;
            rk_idx     <= '0;
            rk_data    <= '0;
            cnt        <= '0;
            rd_ptr     <= '0;
        end else begin
            case (state)
                IDLE, READY: begin
                    if (state == READY && strm_start) begin
                        state   <= STREAM;
                        rd_ptr  <= LAST_IDX;
                        rk_data <= rf_rdata;
                        rk_idx  <= LAST_IDX;
                        rk_vld  <= 1'b1;
                        rk_last <= 1'b0;
                    end else if (key_accept) begin
                        exp_kt     <= key_in;
                        exp_kt_vld <= 1'b1;
                        key_valid  <= 1'b0;
                        key_err    <= 1'b0;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (exp_kt_rdy) begin
                        exp_kt_vld <= 1'b0;
                        cnt        <= IDX_W'(1);
                        state      <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (exp_rkey_vld) begin
                        if (exp_rkey_last) begin
                            if (cnt == LAST_IDX) begin
                                key_valid <= 1'b1;
                                state     <= READY;
                            end else begin
                                key_err   <= 1'b1;
                                key_valid <= 1'b0;
                                state     <= IDLE;
                            end
                        end else if (cnt == LAST_IDX) begin
                            key_err <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            cnt <= cnt + IDX_W'(1);
                        end
                    end
                end
                STREAM: begin
                    if (rk_rdy) begin
                        if (rk_last) begin
                            rk_vld  <= 1'b0;
                            rk_last <= 1'b0;
                            state   <= READY;
                        end else begin
                            rd_ptr  <= rd_ptr - IDX_W'(1);
                            rk_data <= rf_rdata;
                            rk_idx  <= rd_ptr - IDX_W'(1);
                            rk_last <= (rd_ptr == IDX_W'(1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_rkey_sched_ctrl.sv
// Directed/randomized bench for aes_rkey_sched_ctrl with a behavioural AES-256 expander and reference schedule.
module tb_aes_rkey_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] key_in;
    logic         key_vld;
    logic         key_rdy;
    logic [255:0] exp_kt;
    logic         exp_kt_vld;
    logic         exp_kt_rdy;
    logic [127:0] exp_rkey;
    logic         exp_rkey_vld;
    logic         exp_rkey_last;
    logic         key_valid;
    logic         key_err;
    logic         strm_start;
    logic         strm_rdy;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic         rk_vld;
    logic         rk_rdy;
    logic         rk_last;

    int checks = 0;
    int errors = 0;

    aes_rkey_sched_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .key_in        (key_in),
        .key_vld       (key_vld),
        .key_rdy       (key_rdy),
        .exp_kt        (exp_kt),
        .exp_kt_vld    (exp_kt_vld),
        .exp_kt_rdy    (exp_kt_rdy),
        .exp_rkey      (exp_rkey),
        .exp_rkey_vld  (exp_rkey_vld),
        .exp_rkey_last (exp_rkey_last),
        .key_valid     (key_valid),
        .key_err       (key_err),
        .strm_start    (strm_start),
        .strm_rdy      (strm_rdy),
        .rk_data       (rk_data),
        .rk_idx        (rk_idx),
        .rk_vld        (rk_vld),
        .rk_rdy        (rk_rdy),
        .rk_last       (rk_last)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    // S-box from the GF(2^8) inverse followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Round key r occupies bits [r*128 +: 128].
    function automatic logic [1919:0] aes256_expand(input logic [255:0] key);
        logic [31:0]   w [0:59];
        logic [31:0]   t;
        logic [7:0]    rcon = 8'h01;
        logic [1919:0] s;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end else if (i % 8 == 4) begin
                t = subword(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) s[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return s;
    endfunction

    // Behavioural expander: round key 0 is combinational in the launch handshake cycle.
    logic [1919:0] ex_sched;
    logic          ex_busy;
    int            ex_i;
    int            ex_idx;
    int            ex_last_at;
    logic          ex_gate;
    logic          ex_hs;

    always_comb ex_sched = aes256_expand(exp_kt);
    assign exp_kt_rdy    = ex_gate && !ex_busy;
    assign ex_hs         = exp_kt_vld && exp_kt_rdy;
    assign ex_idx        = ex_busy ? ex_i : 0;
    assign exp_rkey_vld  = ex_hs || ex_busy;
    assign exp_rkey      = ex_sched[ex_idx*128 +: 128];
    assign exp_rkey_last = exp_rkey_vld && (ex_idx == ex_last_at);

    always @(posedge clk) begin
        if (rst) begin
            ex_busy <= 1'b0;
            ex_i    <= 0;
        end else if (ex_hs) begin
            ex_busy <= (ex_last_at != 0);
            ex_i    <= 1;
        end else if (ex_busy) begin
            if (exp_rkey_last) ex_busy <= 1'b0;
            ex_i <= ex_i + 1;
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom();
        return k;
    endfunction

    // Caller is at a negedge in IDLE/READY; key_vld may already be high.
    task automatic do_load(input logic [255:0] key, input int delay, input int last_at);
        int lat;
        bit done;
        bit ok;
        ex_last_at = last_at;
        ex_gate    = (delay == 0);
        key_in     = key;
        key_vld    = 1'b1;
        #1;
        check("key_rdy_at_load", key_rdy, 1);
        @(negedge clk);
        key_vld = 1'b0;
        lat  = 1;
        done = 1'b0;
        check("key_valid_drop", key_valid, 0);
        check("key_err_clear", key_err, 0);
        check("exp_kt", exp_kt, key);
        while (!done && lat < 100) begin
            if (lat <= delay + 1) begin
                check("exp_kt_vld_wait", exp_kt_vld, 1);
                check("exp_kt_stable", exp_kt, key);
            end
            if (lat == delay + 2) check("exp_kt_vld_done", exp_kt_vld, 0);
            if (lat == delay + 1) ex_gate = 1'b1;
            if (key_valid || key_err) done = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        ex_gate = 1'b1;
        ok = (last_at == 14);
        check("load_latency", lat, delay + last_at + 2);
        check("key_valid_end", key_valid, ok);
        check("key_err_end", key_err, !ok);
        check("strm_rdy_end", strm_rdy, ok);
        check("key_rdy_end", key_rdy, 1);
    endtask

    // Caller is at a negedge in READY; beats must come out as round keys NR..0 of key.
    task automatic do_stream(input logic [255:0] key, input bit stall,
                             output logic [127:0] first, output logic [127:0] last);
        logic [1919:0] sch;
        int exp_idx;
        int cyc;
        sch   = aes256_expand(key);
        first = '0;
        last  = '0;
        check("strm_rdy_pre", strm_rdy, 1);
        strm_start = 1'b1;
        #1;
        check("key_rdy_on_start", key_rdy, 0);
        @(negedge clk);
        strm_start = 1'b0;
        check("first_beat_latency", rk_vld, 1);
        exp_idx = 14;
        cyc     = 0;
        while (exp_idx >= 0 && cyc < 400) begin
            check("rk_vld", rk_vld, 1);
            check("rk_idx", rk_idx, exp_idx);
            check("rk_data", rk_data, sch[exp_idx*128 +: 128]);
            check("rk_last", rk_last, exp_idx == 0);
            check("key_rdy_stream", key_rdy, 0);
            check("strm_rdy_stream", strm_rdy, 0);
            if (exp_idx == 14) first = rk_data;
            if (exp_idx == 0) last = rk_data;
            rk_rdy = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (rk_rdy) exp_idx--;
            @(negedge clk);
            cyc++;
        end
        rk_rdy = 1'b1;
        check("stream_len", exp_idx, -1);
        check("rk_vld_after", rk_vld, 0);
        check("strm_rdy_after", strm_rdy, 1);
    endtask

    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    localparam logic [127:0] FIPS_RK0  = 128'h000102030405060708090a0b0c0d0e0f;

    initial begin
        logic [255:0] k1, k2, k3, k4, k5;
        logic [127:0] f0, l0, f1, l1;
        rst = 1'b1; key_in = '0; key_vld = 1'b0; strm_start = 1'b0; rk_rdy = 1'b1;
        ex_gate = 1'b1; ex_last_at = 14;
        repeat (2) @(negedge clk);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_err", key_err, 0);
        check("rst_rk_vld", rk_vld, 0);
        check("rst_rk_last", rk_last, 0);
        check("rst_exp_kt_vld", exp_kt_vld, 0);
        check("rst_rk_idx", rk_idx, 0);
        check("rst_rk_data", rk_data, 0);
        check("rst_strm_rdy", strm_rdy, 0);
        check("rst_key_rdy", key_rdy, 1);
        rst = 1'b0;
        @(negedge clk);

        strm_start = 1'b1;
        @(negedge clk);
        strm_start = 1'b0;
        check("idle_ignore_start_vld", rk_vld, 0);
        check("idle_ignore_start_rdy", strm_rdy, 0);

        do_load(FIPS_KEY, 0, 14);
        do_stream(FIPS_KEY, 1'b0, f0, l0);
        check("fips_rk14", f0, FIPS_RK14);
        check("fips_rk0", l0, FIPS_RK0);
        do_stream(FIPS_KEY, 1'b1, f1, l1);
        check("stall_first_same", f1, FIPS_RK14);
        check("stall_last_same", l1, FIPS_RK0);

        k1 = rand_key();
        do_load(k1, 5, 14);
        do_stream(k1, 1'b1, f0, l0);

        // Key offered together with strm_start: the stream must use the old key.
        k2 = rand_key();
        key_in  = k2;
        key_vld = 1'b1;
        do_stream(k1, 1'b0, f0, l0);
        do_load(k2, 0, 14);
        do_stream(k2, 1'b1, f0, l0);

        k3 = rand_key();
        do_load(k3, 0, 9);
        do_load(k3, 0, 14);
        do_stream(k3, 1'b0, f0, l0);

        k4 = rand_key();
        key_in  = k4;
        key_vld = 1'b1;
        @(negedge clk);
        key_vld = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_capture_busy", strm_rdy, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_key_valid", key_valid, 0);
        check("abort_key_rdy", key_rdy, 1);
        check("abort_strm_rdy", strm_rdy, 0);
        check("abort_exp_kt_vld", exp_kt_vld, 0);
        strm_start = 1'b1;
        @(negedge clk);
        strm_start = 1'b0;
        check("abort_ignore_start", rk_vld, 0);
        k5 = rand_key();
        do_load(k5, 0, 14);
        do_stream(k5, 1'b1, f0, l0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
